sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
- Serial pattern transmitter. It is the driving end of the single-bit `input_sequence` stream consumed by `sequence_detector_behavioral` and `sequence_detector_structural`.
- It accepts a PATTERN_W-bit pattern and a repeat count through a valid/ready handshake.
- It shifts the pattern out MSB-first, one bit per clock, back-to-back for (repeat+1) passes, then pulses `done`.
- It is used as the stimulus source in detector benches and in a generator-to-detector loopback.

Parameters:
- PATTERN_W, 5, number of pattern bits per pass (minimum 2).
- COUNT_W, 4, width of the repeat counter. Maximum passes = 2**COUNT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pattern_i  in  PATTERN_W  pattern to transmit, MSB sent first.
- repeat_i  in  COUNT_W  additional passes after the first; 0 means one pass.
- start_valid  in  1  request to start a transmission.
- start_ready  out  1  high only in IDLE; handshake completes on a clock edge where start_valid && start_ready.
- sequence_out  out  1  serial bit stream, connects to a detector's `input_sequence`.
- bit_valid  out  1  high while sequence_out carries a transmitted bit.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - sequence_out=0, bit_valid=0, busy=0, done=0, start_ready=1.
  - State returns to IDLE; shift register and counters clear.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states:
  - IDLE:
    - start_ready=1; sequence_out=0; bit_valid=0.
    - On handshake: latch pattern_i and repeat_i, go to SHIFT.
  - SHIFT:
    - The first bit (pattern[PATTERN_W-1]) appears with bit_valid=1 in the cycle after the handshake edge.
    - A bit counter advances each cycle.
    - After the LSB: if pass counter > 0, decrement it, reload the latched pattern and send its MSB in the very next cycle (no gap). Otherwise go to DONE.
  - DONE:
    - done=1 for exactly one cycle; bit_valid=0; sequence_out=0.
    - Next state IDLE; start_ready rises the cycle after done.
- Latency:
  - Handshake edge to first bit: 1 cycle.
  - Total valid bits: (repeat_i+1)*PATTERN_W, contiguous.
  - done appears in the cycle immediately after the last valid bit.
- Inputs while busy: pattern_i, repeat_i and start_valid are ignored, since start_ready=0. A held start_valid is accepted on the first IDLE edge.
- repeat_i all-ones: 2**COUNT_W passes. The pass counter counts down to 0 and never wraps.
- start_valid already high when reset releases: accepted on the first clock edge after release.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined: after the LSB of every pass, one extra bit equal to the XOR of the latched pattern bits (even parity) is sent with bit_valid=1.
  - Pass length becomes PATTERN_W+1.
  - The next pass or DONE follows the parity bit.
- Undefined: no parity slot; pass length is PATTERN_W.

Decomposition:
- Shared package `sequence_generator_pkg`:
  - State enum typedef: IDLE, SHIFT, DONE.
  - Default constants for PATTERN_W and COUNT_W.
  - Localparam for the pass length (PATTERN_W or PATTERN_W+1 under SEQGEN_PARITY_EN).
- One sub-module, `seqgen_shift_reg`: PATTERN_W-bit loadable MSB-first shift register with load, shift and a serial MSB output. The FSM and counters stay in the top.

Test Plan:
1. Single pass of 11111: pattern_i=5'b11111, repeat_i=0, pulse start_valid.
   - sequence_out=1 with bit_valid=1 for exactly 5 cycles starting 1 cycle after the handshake.
   - done pulses in cycle 6; start_ready returns in cycle 7.
   - In loopback, the detectors assert detected.
2. Three passes of 01101: pattern_i=5'b01101, repeat_i=2.
   - Contiguous 15-bit stream 011010110101101, bit_valid high all 15 cycles.
   - One done pulse after the 15th bit.
3. Busy rejection: start_valid held high with pattern 10101 during a transmission of 11111.
   - start_ready=0 and the stream is unaffected.
   - 10101 is accepted on the first IDLE edge.
4. Reset mid-shift: assert rst_n=0 after 2 bits of 11111.
   - Immediately sequence_out=0, bit_valid=0, busy=0, start_ready=1; no done pulse.
   - A new handshake after release works normally.
5. Maximum repeats: repeat_i=4'hF with pattern 10000.
   - Exactly 80 valid bits (16 passes), then a single done; no counter wrap.
6. Parity (SEQGEN_PARITY_EN defined): pattern_i=5'b10110, repeat_i=1.
   - Stream 101101101101, i.e. 12 bits with the parity bit = 1 after each pass, then done.

Source files
------------

// File: rtl/sequence_generator_pkg.sv
// ============================================================================
// Module      : sequence_generator_pkg
// Description : Shared types and constants for the serial pattern generator.
//               SEQGEN_PARITY_EN adds an even-parity slot to every pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_PATTERN_W = 5;
  localparam int DEFAULT_COUNT_W   = 4;

`ifdef SEQGEN_PARITY_EN
  localparam int PARITY_SLOTS = 1;
`else
  localparam int PARITY_SLOTS = 0;
`endif

  localparam int DEFAULT_PASS_LEN = DEFAULT_PATTERN_W + PARITY_SLOTS;

endpackage

`default_nettype wire

// File: rtl/seqgen_shift_reg.sv
// ============================================================================
// Module      : seqgen_shift_reg
// Description : Loadable MSB-first shift register; load has priority over shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seqgen_shift_reg #(
  parameter int PATTERN_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [PATTERN_W-1:0] i_data,
  output logic                 o_msb
);

  logic [PATTERN_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[PATTERN_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[PATTERN_W-1];

endmodule

`default_nettype wire

// File: rtl/sequence_generator.sv
// ============================================================================
// Module      : sequence_generator
// Description : Serial pattern transmitter, MSB-first, (repeat+1) contiguous
//               passes then a done pulse. SEQGEN_PARITY_EN appends a parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int PATTERN_W = DEFAULT_PATTERN_W,
  parameter int COUNT_W   = DEFAULT_COUNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [COUNT_W-1:0]   repeat_i,
  input  logic                 start_valid,
  output logic                 start_ready,
  output logic                 sequence_out,
  output logic                 bit_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int C_PASS_LEN  = PATTERN_W + PARITY_SLOTS;
  localparam int C_BIT_CNT_W = (C_PASS_LEN > 1) ? $clog2(C_PASS_LEN) : 1;
  localparam logic [C_BIT_CNT_W-1:0] C_LAST_BIT = C_BIT_CNT_W'(C_PASS_LEN - 1);
`ifdef SEQGEN_PARITY_EN
  localparam logic [C_BIT_CNT_W-1:0] C_PARITY_SLOT = C_BIT_CNT_W'(PATTERN_W);
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PATTERN_W-1:0]   r_pattern;
  logic [COUNT_W-1:0]     r_pass_cnt;
  logic [C_BIT_CNT_W-1:0] r_bit_cnt;

  logic                 w_handshake;
  logic                 w_in_shift;
  logic                 w_last_bit;
  logic                 w_reload;
  logic                 w_load;
  logic                 w_shift;
  logic [PATTERN_W-1:0] w_load_data;
  logic                 w_msb;
  logic                 w_serial;

  assign w_handshake = start_valid && (r_state == IDLE);
  assign w_in_shift  = (r_state == SHIFT);
  assign w_last_bit  = w_in_shift && (r_bit_cnt == C_LAST_BIT);
  assign w_reload    = w_last_bit && (r_pass_cnt != '0);
  assign w_load      = w_handshake || w_reload;
  assign w_shift     = w_in_shift && !w_last_bit;
  assign w_load_data = w_handshake ? pattern_i : r_pattern;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_state_nxt = SHIFT;
      SHIFT:   if (w_last_bit && (r_pass_cnt == '0)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pass counter saturates at zero; the final pass leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern  <= '0;
      r_pass_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_handshake) begin
      r_pattern  <= pattern_i;
      r_pass_cnt <= repeat_i;
      r_bit_cnt  <= '0;
    end else if (w_in_shift) begin
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        if (r_pass_cnt != '0) begin
          r_pass_cnt <= r_pass_cnt - 1'b1;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  seqgen_shift_reg #(
    .PATTERN_W (PATTERN_W)
  ) u_shift_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

`ifdef SEQGEN_PARITY_EN
  assign w_serial = (r_bit_cnt == C_PARITY_SLOT) ? (^r_pattern) : w_msb;
`else
  assign w_serial = w_msb;
`endif

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    start_ready  = 1'b0;
    sequence_out = 1'b0;
    bit_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
      end
      SHIFT: begin
        sequence_out = w_serial;
        bit_valid    = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_generator.sv
// ============================================================================
// Module      : tb_sequence_generator
// Description : Self-checking bench for sequence_generator (vector table,
//               directed corner cases, random transactions vs. queue model).
//               Expectations follow SEQGEN_PARITY_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_generator;

  localparam int PW = 5;
  localparam int CW = 4;
`ifdef SEQGEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PLEN = PW + PAR;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] pattern_i;
  logic [CW-1:0] repeat_i;
  logic          start_valid;
  logic          start_ready;
  logic          sequence_out;
  logic          bit_valid;
  logic          busy;
  logic          done;

  sequence_generator #(
    .PATTERN_W (PW),
    .COUNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pattern_i    (pattern_i),
    .repeat_i     (repeat_i),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .sequence_out (sequence_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit exp_q[$];
  bit got_q[$];

  typedef struct {
    logic [PW-1:0] pat;
    logic [CW-1:0] rep;
    int            exp_len;
    int            exp_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference stream: each pass is the pattern MSB-first, optionally followed by its even parity.
  function automatic void build_expected(input logic [PW-1:0] pat, input logic [CW-1:0] rep);
    exp_q.delete();
    for (int p = 0; p <= int'(rep); p++) begin
      for (int i = PW - 1; i >= 0; i--) exp_q.push_back(pat[i]);
      if (PAR == 1) exp_q.push_back(^pat);
    end
  endfunction

  task automatic compare_stream(input string name);
    int first_bad;
    first_bad = -1;
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i] != exp_q[i] && first_bad < 0) first_bad = i;
      end
    end else begin
      first_bad = 0;
    end
    n_total++;
    if (first_bad < 0) n_pass++;
    else $display("FAIL %s: got %0d bits, expected %0d bits, first bad index %0d",
                  name, got_q.size(), exp_q.size(), first_bad);
  endtask

  // Starts one cycle after the handshake edge (+1 time unit) and stops on the done cycle.
  task automatic collect(input string name, input int budget);
    bit saw_done;
    bit gap;
    bit ready_bad;
    saw_done  = 1'b0;
    gap       = 1'b0;
    ready_bad = 1'b0;
    got_q.delete();
    for (int c = 0; c < budget; c++) begin
      if (start_ready) ready_bad = 1'b1;
      if (done) begin
        saw_done = 1'b1;
        if (bit_valid || sequence_out || !busy) gap = 1'b1;
        break;
      end
      if (!bit_valid || !busy) gap = 1'b1;
      else got_q.push_back(sequence_out);
      @(posedge clk); #1;
    end
    check({name, "_done_seen"}, 64'(saw_done), 64'd1);
    check({name, "_contiguous"}, 64'(gap), 64'd0);
    check({name, "_ready_low"}, 64'(ready_bad), 64'd0);
  endtask

  task automatic finish_txn(input string name);
    @(posedge clk); #1;
    check({name, "_idle_after"}, {59'd0, start_ready, done, busy, bit_valid, sequence_out},
          64'b10000);
  endtask

  task automatic send_and_check(input string name, input logic [PW-1:0] pat,
                                input logic [CW-1:0] rep);
    @(negedge clk);
    check({name, "_ready_before"}, 64'(start_ready), 64'd1);
    pattern_i   = pat;
    repeat_i    = rep;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    build_expected(pat, rep);
    collect(name, (int'(rep) + 1) * PLEN + 8);
    compare_stream({name, "_stream"});
    finish_txn(name);
  endtask

  function automatic logic [63:0] pack_got();
    logic [63:0] acc;
    acc = '0;
    foreach (got_q[i]) acc = {acc[62:0], got_q[i]};
    return acc;
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int ones;
    bit done_seen;

`ifdef SEQGEN_PARITY_EN
    vecs[0] = '{5'b11111, 4'd0, 6, 6};
    vecs[1] = '{5'b01101, 4'd2, 18, 12};
    vecs[2] = '{5'b10000, 4'hF, 96, 32};
    vecs[3] = '{5'b10101, 4'd1, 12, 8};
    vecs[4] = '{5'b00000, 4'd0, 6, 0};
    vecs[5] = '{5'b00001, 4'd3, 24, 8};
`else
    vecs[0] = '{5'b11111, 4'd0, 5, 5};
    vecs[1] = '{5'b01101, 4'd2, 15, 9};
    vecs[2] = '{5'b10000, 4'hF, 80, 16};
    vecs[3] = '{5'b10101, 4'd1, 10, 6};
    vecs[4] = '{5'b00000, 4'd0, 5, 0};
    vecs[5] = '{5'b00001, 4'd3, 20, 4};
`endif

    rst_n       = 1'b0;
    pattern_i   = '0;
    repeat_i    = '0;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {59'd0, start_ready, done, busy, bit_valid, sequence_out}, 64'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_and_check($sformatf("vec%0d", v), vecs[v].pat, vecs[v].rep);
      ones = 0;
      foreach (got_q[i]) ones += int'(got_q[i]);
      check($sformatf("vec%0d_len", v), 64'(got_q.size()), 64'(vecs[v].exp_len));
      check($sformatf("vec%0d_ones", v), 64'(ones), 64'(vecs[v].exp_ones));
    end

`ifdef SEQGEN_PARITY_EN
    send_and_check("three_pass", 5'b01101, 4'd2);
    check("three_pass_literal", pack_got(), 64'b011011011011011011);
    send_and_check("parity", 5'b10110, 4'd1);
    check("parity_literal", pack_got(), 64'b101101101101);
`else
    send_and_check("three_pass", 5'b01101, 4'd2);
    check("three_pass_literal", pack_got(), 64'b011010110101101);
    send_and_check("two_pass", 5'b10110, 4'd1);
    check("two_pass_literal", pack_got(), 64'b1011010110);
`endif

    // Busy rejection: a second request is held through the whole first transmission.
    @(negedge clk);
    pattern_i   = 5'b11111;
    repeat_i    = 4'd0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    pattern_i = 5'b10101;
    build_expected(5'b11111, 4'd0);
    collect("busy_first", PLEN + 8);
    compare_stream("busy_first_stream");
    finish_txn("busy_first");
    @(posedge clk); #1;
    start_valid = 1'b0;
    build_expected(5'b10101, 4'd0);
    collect("busy_second", PLEN + 8);
    compare_stream("busy_second_stream");
    finish_txn("busy_second");

    // Reset in the middle of a shift must clear outputs immediately.
    @(negedge clk);
    pattern_i   = 5'b11111;
    repeat_i    = 4'd0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("midrst_bit0", {62'd0, bit_valid, sequence_out}, 64'b11);
    @(posedge clk); #1;
    check("midrst_bit1", {62'd0, bit_valid, sequence_out}, 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_immediate", {59'd0, start_ready, done, busy, bit_valid, sequence_out},
          64'b10000);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    check("midrst_quiet", 64'(done_seen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_and_check("after_rst", 5'b11001, 4'd1);

    // Request already pending when reset releases.
    @(negedge clk);
    rst_n       = 1'b0;
    pattern_i   = 5'b01011;
    repeat_i    = 4'd0;
    start_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    build_expected(5'b01011, 4'd0);
    collect("rel_valid", PLEN + 8);
    compare_stream("rel_valid_stream");
    finish_txn("rel_valid");

    for (int t = 0; t < 20; t++) begin
      logic [PW-1:0] rp;
      logic [CW-1:0] rr;
      rp = PW'($urandom);
      rr = CW'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_and_check($sformatf("rand%0d", t), rp, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
